// File: rtl/clk_div_monitor.sv
// Checks a divided clock derived from clk: measures period and high time in clk
// cycles, compares against expected values, tracks lock and flags loss of lock.
module clk_div_monitor #(
    parameter int CNT_W       = 8,
    parameter int LOCK_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_div_in,
    input  logic [CNT_W-1:0] exp_n,
    input  logic [CNT_W-1:0] exp_high,
    input  logic             clr_err,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             match,
    output logic             locked,
    output logic             err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_PRE = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] MIN_N   = CNT_W'(2);
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_CYCLES);

    state_t           r_state;
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [3:0]       r_good;

    logic       w_rise;
    logic       w_match;
    logic       w_timeout;
    logic       w_err_set;
    logic [3:0] w_good_inc;

    assign w_rise     = clk_div_in & ~r_prev;
    assign w_match    = (r_cnt == exp_n) && (r_hcnt == exp_high) && (exp_n >= MIN_N);
    // Timeout fires on the edge where cnt steps into saturation, so it happens once.
    assign w_timeout  = !w_rise && (r_cnt == CNT_PRE) && (r_state != ST_IDLE);
    assign w_err_set  = (r_state == ST_LOCK) && ((w_rise && !w_match) || w_timeout);
    assign w_good_inc = r_good + 4'd1;
    assign dbg_state  = r_state;

    // Previous sample resets high so an input already high at release is no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b1;
            r_cnt  <= '0;
            r_hcnt <= '0;
        end else begin
            r_prev <= clk_div_in;
            if (w_rise) begin
                r_cnt  <= CNT_W'(1);
                r_hcnt <= CNT_W'(1);
            end else begin
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (clk_div_in && (r_hcnt != CNT_MAX)) begin
                    r_hcnt <= r_hcnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_good     <= 4'd0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            match      <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (w_err_set) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    r_good <= 4'd0;
                    if (w_rise) begin
                        r_state <= ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (w_timeout) begin
                        r_state <= ST_IDLE;
                        r_good  <= 4'd0;
                        locked  <= 1'b0;
                        match   <= 1'b0;
                    end else if (w_rise) begin
                        period     <= r_cnt;
                        high_time  <= r_hcnt;
                        meas_valid <= 1'b1;
                        match      <= w_match;
                        if (w_match) begin
                            r_good <= w_good_inc;
                            if (w_good_inc == LOCK_N) begin
                                r_state <= ST_LOCK;
                                locked  <= 1'b1;
                            end
                        end else begin
                            r_good <= 4'd0;
                        end
                    end
                end
                ST_LOCK: begin
                    if (w_timeout) begin
                        r_state <= ST_IDLE;
                        r_good  <= 4'd0;
                        locked  <= 1'b0;
                        match   <= 1'b0;
                    end else if (w_rise) begin
                        period     <= r_cnt;
                        high_time  <= r_hcnt;
                        meas_valid <= 1'b1;
                        match      <= w_match;
                        if (!w_match) begin
                            r_state <= ST_TRACK;
                            r_good  <= 4'd0;
                            locked  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_good  <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: each table row is one input period, checked
// at the rise that starts it; stuck-clock and reset cases are hand sequences.
module tb_clk_div_monitor;

    logic       clk;
    logic       rst_n;
    logic       clk_div_in;
    logic [7:0] exp_n;
    logic [7:0] exp_high;
    logic       clr_err;
    logic [7:0] period;
    logic [7:0] high_time;
    logic       meas_valid;
    logic       match;
    logic       locked;
    logic       err;
    logic [1:0] dbg_state;

    int total;
    int bad;

    typedef struct {
        int         h;
        int         l;
        logic [7:0] en;
        logic [7:0] eh;
        logic       clr;
        logic       mv;
        logic [7:0] p;
        logic [7:0] ht;
        logic       m;
        logic       lk;
        logic       e;
    } vec_t;

    vec_t vecs [0:32];

    clk_div_monitor #(.CNT_W(8), .LOCK_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_div_in (clk_div_in),
        .exp_n      (exp_n),
        .exp_high   (exp_high),
        .clr_err    (clr_err),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .match      (match),
        .locked     (locked),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int h, input int l, input logic [7:0] en,
                                input logic [7:0] eh, input logic clr, input logic mv,
                                input logic [7:0] p, input logic [7:0] ht, input logic m,
                                input logic lk, input logic e);
        vec_t v;
        v.h = h; v.l = l; v.en = en; v.eh = eh; v.clr = clr; v.mv = mv;
        v.p = p; v.ht = ht; v.m = m; v.lk = lk; v.e = e;
        return v;
    endfunction

    task automatic chk_all(input string tag, input logic mv, input logic [7:0] p,
                           input logic [7:0] ht, input logic m, input logic lk, input logic e);
        chk({tag, ".meas_valid"}, 32'(meas_valid), 32'(mv));
        chk({tag, ".period"}, 32'(period), 32'(p));
        chk({tag, ".high_time"}, 32'(high_time), 32'(ht));
        chk({tag, ".match"}, 32'(match), 32'(m));
        chk({tag, ".locked"}, 32'(locked), 32'(lk));
        chk({tag, ".err"}, 32'(err), 32'(e));
    endtask

    task automatic apply_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        exp_n    = v.en;
        exp_high = v.eh;
        for (int c = 0; c < v.h + v.l; c++) begin
            clk_div_in = (c < v.h);
            clr_err    = (c == 0) ? v.clr : 1'b0;
            step();
            clr_err = 1'b0;
            if (c == 0) begin
                chk_all($sformatf("vec%0d", idx), v.mv, v.p, v.ht, v.m, v.lk, v.e);
            end else begin
                chk($sformatf("vec%0d.no_mv_c%0d", idx, c), 32'(meas_valid), 32'd0);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        // h, l, exp_n, exp_high, clr | mv, period, high_time, match, locked, err
        vecs[0]  = mk(3, 2, 5, 3, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(3, 2, 5, 3, 0, 1, 5, 3, 1, 0, 0);
        vecs[2]  = mk(3, 2, 5, 3, 0, 1, 5, 3, 1, 0, 0);
        vecs[3]  = mk(3, 2, 5, 3, 0, 1, 5, 3, 1, 0, 0);
        vecs[4]  = mk(3, 2, 5, 3, 0, 1, 5, 3, 1, 1, 0);
        vecs[5]  = mk(3, 2, 5, 3, 0, 1, 5, 3, 1, 1, 0);
        vecs[6]  = mk(3, 3, 5, 3, 0, 1, 5, 3, 1, 1, 0);
        vecs[7]  = mk(3, 3, 5, 3, 0, 1, 6, 3, 0, 0, 1);
        vecs[8]  = mk(3, 3, 6, 3, 0, 1, 6, 3, 1, 0, 1);
        vecs[9]  = mk(3, 3, 6, 3, 0, 1, 6, 3, 1, 0, 1);
        vecs[10] = mk(3, 3, 6, 3, 0, 1, 6, 3, 1, 0, 1);
        vecs[11] = mk(3, 3, 6, 3, 0, 1, 6, 3, 1, 1, 1);
        vecs[12] = mk(3, 3, 6, 3, 0, 1, 6, 3, 1, 1, 1);
        vecs[13] = mk(3, 3, 6, 3, 1, 1, 6, 3, 1, 1, 0);
        vecs[14] = mk(3, 2, 6, 3, 0, 1, 6, 3, 1, 1, 0);
        vecs[15] = mk(3, 2, 6, 3, 1, 1, 5, 3, 0, 0, 1);
        vecs[16] = mk(2, 3, 5, 3, 0, 1, 5, 3, 1, 0, 1);
        vecs[17] = mk(2, 3, 5, 2, 0, 1, 5, 2, 1, 0, 1);
        vecs[18] = mk(2, 3, 5, 3, 0, 1, 5, 2, 0, 0, 1);
        vecs[19] = mk(2, 3, 5, 2, 1, 1, 5, 2, 1, 0, 0);
        vecs[20] = mk(2, 3, 5, 2, 0, 1, 5, 2, 1, 0, 0);
        vecs[21] = mk(2, 3, 5, 2, 0, 1, 5, 2, 1, 0, 0);
        vecs[22] = mk(2, 3, 5, 2, 0, 1, 5, 2, 1, 1, 0);
        vecs[23] = mk(3, 2, 5, 3, 0, 0, 5, 2, 0, 0, 1);
        vecs[24] = mk(3, 2, 5, 3, 0, 1, 5, 3, 1, 0, 1);
        vecs[25] = mk(3, 2, 5, 3, 0, 0, 0, 0, 0, 0, 0);
        vecs[26] = mk(3, 2, 5, 3, 0, 1, 5, 3, 1, 0, 0);
        vecs[27] = mk(1, 1, 1, 1, 0, 1, 5, 3, 0, 0, 0);
        vecs[28] = mk(1, 1, 1, 1, 0, 1, 2, 1, 0, 0, 0);
        vecs[29] = mk(1, 1, 1, 1, 0, 1, 2, 1, 0, 0, 0);
        vecs[30] = mk(1, 1, 1, 1, 0, 1, 2, 1, 0, 0, 0);
        vecs[31] = mk(1, 1, 1, 1, 0, 1, 2, 1, 0, 0, 0);
        vecs[32] = mk(1, 1, 2, 1, 0, 1, 2, 1, 1, 0, 0);

        rst_n      = 1'b0;
        clk_div_in = 1'b0;
        exp_n      = 8'd0;
        exp_high   = 8'd0;
        clr_err    = 1'b0;
        step();
        step();
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();

        for (int i = 0; i <= 22; i++) apply_vec(i);

        // Stuck-low input after lock: timeout must drop lock and set err.
        begin
            int mv_seen;
            mv_seen = 0;
            clk_div_in = 1'b0;
            for (int i = 0; i < 240; i++) begin
                step();
                if (meas_valid) mv_seen++;
            end
            chk("stuck.locked_before", 32'(locked), 32'd1);
            chk("stuck.err_before", 32'(err), 32'd0);
            for (int i = 0; i < 20; i++) begin
                step();
                if (meas_valid) mv_seen++;
            end
            chk("stuck.mv_count", 32'(mv_seen), 32'd0);
            chk_all("stuck.after", 0, 5, 2, 0, 0, 1);
        end

        for (int i = 23; i <= 24; i++) apply_vec(i);

        // Asynchronous reset mid-period with the input high.
        clk_div_in = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk_all("rst_mid", 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("rst_rel.hi_no_mv%0d", i), 32'(meas_valid), 32'd0);
        end
        clk_div_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("rst_rel.lo_no_mv%0d", i), 32'(meas_valid), 32'd0);
        end
        chk_all("rst_rel.state", 0, 0, 0, 0, 0, 0);

        for (int i = 25; i <= 32; i++) apply_vec(i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Checks a divided clock produced from the same `clk` by a synchronous mod-N divider.
- Measures the period and high time of `clk_div_in` in `clk` cycles and compares them against expected values.
- Declares lock after consecutive good periods and flags loss of lock with a sticky error.
- Sits next to the divider blocks as a built-in checker; the bench can also reuse it as a self-checking monitor.

Parameters:
- CNT_W, 8, width of period/high-time counters and expected-value inputs.
- LOCK_CYCLES, 4, consecutive matching periods required to assert locked (range 1..15).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- clk_div_in  input  1  divided clock under test; synchronous to clk, no synchronizer.
- exp_n  input  CNT_W  expected period in clk cycles.
- exp_high  input  CNT_W  expected high time in clk cycles.
- clr_err  input  1  synchronous clear of err.
- period  output  CNT_W  last measured period.
- high_time  output  CNT_W  last measured high time.
- meas_valid  output  1  one-cycle pulse; period/high_time updated.
- match  output  1  last measurement equal to exp_n and exp_high.
- locked  output  1  LOCK_CYCLES consecutive matches seen.
- err  output  1  sticky loss-of-lock/timeout flag.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. The previous-sample register resets to 1, so a high input at reset release is not a rising edge.
- Edge detect: `rise` = clk_div_in & ~prev, where prev is clk_div_in registered.
- Counters, on a rise cycle: cnt := 1, hcnt := 1.
- Counters, on other cycles:
  - cnt increments.
  - hcnt increments when clk_div_in = 1, otherwise holds.
- Example: mod-5 with 3 high cycles measures period = 5, high_time = 3.
- cnt saturates at 2^CNT_W-1. Reaching saturation in TRACK or LOCK is a timeout.
- State IDLE:
  - The first rise moves to TRACK.
  - No measurement is published (no prior edge).
- State TRACK, on each rise:
  - Publish period := cnt, high_time := hcnt, and assert meas_valid.
  - Outputs are registered: they update at the clk edge following the rise cycle.
  - match := (cnt == exp_n) && (hcnt == exp_high) && (exp_n >= 2).
  - On a match, increment good_cnt. When good_cnt reaches LOCK_CYCLES, move to LOCK and set locked := 1 in the same update.
  - On a mismatch, good_cnt := 0.
- State LOCK, on each rise: publish as above.
  - On a mismatch: locked := 0, err := 1, good_cnt := 0, move to TRACK. All of this happens in the same cycle as meas_valid.
- Timeout (TRACK or LOCK):
  - Move to IDLE, good_cnt := 0, locked := 0, match := 0.
  - err := 1 only if the state was LOCK.
  - period and high_time hold their values; no meas_valid.
- exp_n < 2: match is always 0; the block never locks.
- exp_n/exp_high changes take effect at the next published measurement. No retroactive re-compare.
- clr_err: clears err on the next edge. A simultaneous set event wins (err stays 1).
- Reset mid-operation: immediate return to reset values. After release, two rises are needed before the first meas_valid.

Test Plan:
1. Lock on a good clock: mod-5 waveform (3 high, 2 low), exp_n=5, exp_high=3.
   - meas_valid every 5 cycles from the 2nd rise, with period=5, high_time=3, match=1.
   - locked=1 with the 4th meas_valid; err=0.
2. Lose lock on a changed ratio: after lock, switch the input to mod-6 (3 high, 3 low).
   - Next meas_valid gives period=6, match=0, locked=0, err=1.
   - With exp_n set to 6, locked returns after 4 further matches; err stays 1.
3. Stuck clock: after lock, hold clk_div_in low.
   - 255 cycles after the last rise: locked=0, err=1, period holds 5, no meas_valid.
   - The next rise alone produces no meas_valid.
4. Reset mid-operation: assert rst_n=0 mid-period with clk_div_in high.
   - All outputs read 0 immediately.
   - After release with the input still high, no false edge; first meas_valid only at the 2nd subsequent rise.
5. Clear and degenerate ratio:
   - clr_err=1 for one cycle with no error event → err=0.
   - clr_err coincident with a locked mismatch → err=1.
   - exp_n=1 with a steady input → match=0 and locked=0 forever.
